mod_n_updown_counter: RTL and testbench
=======================================

MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 Parameter N, default 10: modulus; legal range N >= 2; out counts over 0..N-1.
REQ-002 Parameter WIDTH, default 4: width of out and load_val; elaboration SHALL fail if 2**WIDTH < N.
REQ-003 Parameter ONESHOT, default 0: 0 = continuous wrap, 1 = single pass then stop.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  level-sampled; launches counting from IDLE or DONE.
REQ-007 en  input  1  count enable; one step per cycle while high in RUN.
REQ-008 up_dn  input  1  direction; 1 = up, 0 = down.
REQ-009 load  input  1  synchronous parallel load strobe (macro-gated, REQ-030).
REQ-010 load_val  input  WIDTH  value for load (macro-gated, REQ-030).
REQ-011 out  output  WIDTH  registered count.
REQ-012 tc  output  1  combinational terminal count: state RUN, en=1, and out = N-1 (up) or 0 (down).
REQ-013 busy  output  1  registered; 1 in RUN.
REQ-014 done  output  1  registered; 1 in DONE (ONESHOT=1 only, else constant 0).

Function
REQ-015 FSM states IDLE, RUN, DONE; DONE is unreachable when ONESHOT=0.
REQ-016 IDLE: out held; start=1 -> RUN next cycle, out unchanged.
REQ-017 RUN, en=0: out held, no state change.
REQ-018 RUN, en=1, up: out <= (out==N-1) ? 0 : out+1.
REQ-019 RUN, en=1, down: out <= (out==0) ? N-1 : out-1.
REQ-020 up_dn change takes effect on the very next enabled step; no dead cycle.
REQ-021 ONESHOT=0: RUN persists until rst; start ignored in RUN.
REQ-022 ONESHOT=1: when tc=1, out holds terminal value (no wrap), FSM -> DONE, busy falls and done rises the next cycle.
REQ-023 DONE: out held; start=1 -> RUN, out <= 0 if up_dn=1, N-1 if up_dn=0.
REQ-024 Priority per cycle: rst > load > start/count.
REQ-025 load=1 with load_val < N: out <= load_val in any state; FSM state unchanged; no count that cycle.
REQ-026 load=1 with load_val >= N: load ignored entirely, normal count/start behaviour applies.
REQ-027 out SHALL never hold a value >= N.

Reset
REQ-028 rst=1 at a clock edge: out=0, state=IDLE, busy=0, done=0 after that edge, regardless of any other input, including mid-RUN or in DONE.
REQ-029 tc SHALL be 0 while state is IDLE or DONE, hence 0 in the cycle after reset.

Configuration
REQ-030 Macro MOD_N_COUNTER_LOAD_EN defined: load and load_val ports exist, REQ-025/026 apply.
REQ-031 Macro undefined: load and load_val ports absent; all other behaviour identical, load treated as 0.

Structure
REQ-032 Package mod_n_counter_pkg holds the FSM state enum (IDLE, RUN, DONE) and default constants for N, WIDTH and ONESHOT.
REQ-033 One combinational sub-module mod_n_step computes next value and terminal flag from out, up_dn, N; FSM and registers stay in the top.

Verification (N=4, WIDTH=3 unless stated)
REQ-034 ONESHOT=0, rst 1 cycle, start pulse, en=1, up: out 0,1,2,3,0,1; tc high exactly on cycles with out=3.
REQ-035 ONESHOT=0, down from 0: out 0,3,2,1,0; tc with out=0; flip up_dn at out=2 -> next out=3.
REQ-036 ONESHOT=1, up: out 0..3, DONE with out=3, done=1, busy=0; start with up_dn=0 -> out=3, RUN, counts 2,1,0 then DONE.
REQ-037 rst asserted mid-RUN at out=2 with en=1, start=1: next out=0, IDLE, busy=0; en toggles without start leave out=0.
REQ-038 Macro defined: load_val=2 with en=1 in RUN -> out=2, no step that cycle; load_val=5 -> ignored, normal step; load in IDLE -> out updates, state stays IDLE.
REQ-039 en=0 for 3 cycles in RUN at out=1: out stays 1, tc=0.

Source files
------------

// File: rtl/mod_n_counter_pkg.sv
// Shared definitions for the mod-N up/down counter: FSM state encoding and
// default parameter values. The optional parallel-load feature is enabled by
// defining MOD_N_COUNTER_LOAD_EN (see mod_n_updown_counter.sv).
package mod_n_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N       = 10;
    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_ONESHOT = 0;

endpackage

// File: rtl/mod_n_step.sv
// Combinational step logic: next count value with wrap, plus the terminal
// flag (at N-1 when counting up, at 0 when counting down).
module mod_n_step #(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_out,
    input  logic             i_up_dn,
    output logic [WIDTH-1:0] o_next,
    output logic             o_term
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(N - 1);

    // Next value wraps at either end of 0..N-1 so out never leaves the range
    always_comb begin
        o_next = i_out;
        o_term = 1'b0;
        if (i_up_dn) begin
            o_term = (i_out == MAX_VAL);
            o_next = o_term ? '0 : i_out + 1'b1;
        end else begin
            o_term = (i_out == '0);
            o_next = o_term ? MAX_VAL : i_out - 1'b1;
        end
    end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Mod-N up/down counter with IDLE/RUN/DONE control FSM and optional one-shot
// mode. Define MOD_N_COUNTER_LOAD_EN to add the load/load_val parallel-load
// ports; without it the counter behaves as if load were tied low.
import mod_n_counter_pkg::*;

module mod_n_updown_counter #(
    parameter int N       = DEFAULT_N,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ONESHOT = DEFAULT_ONESHOT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             up_dn,
`ifdef MOD_N_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(N - 1);

    // Reject configurations where the modulus cannot be represented
    if (N < 2) begin : g_bad_n
        $error("mod_n_updown_counter: N must be >= 2");
    end
    if ((2 ** WIDTH) < N) begin : g_bad_width
        $error("mod_n_updown_counter: WIDTH too small for N");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_next;
    logic             w_term;
    logic             w_load_ok;

    mod_n_step #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_step (
        .i_out   (r_out),
        .i_up_dn (up_dn),
        .o_next  (w_next),
        .o_term  (w_term)
    );

`ifdef MOD_N_COUNTER_LOAD_EN
    // Out-of-range load values are dropped so out stays inside 0..N-1
    localparam logic [WIDTH:0] N_EXT = (WIDTH + 1)'(N);
    assign w_load_ok = load && ({1'b0, load_val} < N_EXT);
`else
    assign w_load_ok = 1'b0;
`endif

    // Control FSM and count register; priority is rst, then load, then start/count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_load_ok) begin
`ifdef MOD_N_COUNTER_LOAD_EN
            r_out <= load_val;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        if ((ONESHOT != 0) && w_term) begin
                            // Single pass finished: park on the terminal value
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_out <= w_next;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_out   <= up_dn ? '0 : MAX_VAL;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign tc   = (r_state == ST_RUN) && en && w_term;
    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Testbench for mod_n_updown_counter (N=4, WIDTH=3): one continuous-wrap and
// one one-shot instance share the same stimulus. Table vectors exercise the
// continuous instance; hand-written sequences cover one-shot and load.
module tb_mod_n_updown_counter;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       en;
        logic       up_dn;
        logic [2:0] out;
        logic       tc;
        logic       busy;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start, en, up_dn;
    logic [2:0] out0, out1;
    logic       tc0, tc1, busy0, busy1, done0, done1;
`ifdef MOD_N_COUNTER_LOAD_EN
    logic       load;
    logic [2:0] load_val;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mod_n_updown_counter #(.N(4), .WIDTH(3), .ONESHOT(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .en       (en),
        .up_dn    (up_dn),
`ifdef MOD_N_COUNTER_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .out      (out0),
        .tc       (tc0),
        .busy     (busy0),
        .done     (done0)
    );

    mod_n_updown_counter #(.N(4), .WIDTH(3), .ONESHOT(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .en       (en),
        .up_dn    (up_dn),
`ifdef MOD_N_COUNTER_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .out      (out1),
        .tc       (tc1),
        .busy     (busy1),
        .done     (done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one vector: tc is checked before the edge, registers after it
    task automatic apply(input vec_t v, input int sel, input string tag);
        logic [2:0] o;
        logic       t, b, d;
        rst   = v.rst;
        start = v.start;
        en    = v.en;
        up_dn = v.up_dn;
        #1;
        t = (sel == 0) ? tc0 : tc1;
        chk({tag, ".tc"}, 32'(t), 32'(v.tc));
        @(posedge clk);
        #1;
        o = (sel == 0) ? out0 : out1;
        b = (sel == 0) ? busy0 : busy1;
        d = (sel == 0) ? done0 : done1;
        chk({tag, ".out"}, 32'(o), 32'(v.out));
        chk({tag, ".busy"}, 32'(b), 32'(v.busy));
        chk({tag, ".done"}, 32'(d), 32'(v.done));
        $display("%s dut%0d: rst=%0d start=%0d en=%0d up=%0d -> out=%0d tc=%0d busy=%0d done=%0d",
                 tag, sel, v.rst, v.start, v.en, v.up_dn, o, t, b, d);
    endtask

`ifdef MOD_N_COUNTER_LOAD_EN
    task automatic do_load(input logic [2:0] lv, input logic e, input logic [2:0] exp_out,
                           input logic exp_busy, input string tag);
        rst      = 1'b0;
        start    = 1'b0;
        en       = e;
        up_dn    = 1'b1;
        load     = 1'b1;
        load_val = lv;
        @(posedge clk);
        #1;
        chk({tag, ".out"}, 32'(out0), 32'(exp_out));
        chk({tag, ".busy"}, 32'(busy0), 32'(exp_busy));
        $display("%s dut0: load_val=%0d en=%0d -> out=%0d busy=%0d", tag, lv, e, out0, busy0);
        load = 1'b0;
    endtask
`endif

    vec_t tbl [27];

    initial begin
        //          rst   start en    up    out   tc    busy  done
        tbl = '{
            '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0},  // reset state
            '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0},  // start: RUN, out held
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0},  // wrap 3->0, tc at 3
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0},  // en low x3: hold
            '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0},  // reset, then count down
            '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0},  // 0 -> 3, tc at 0
            '{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0},  // flip to up at 2 -> 3
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0},  // start ignored in RUN
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0},  // rst wins over en/start
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0},  // IDLE: en alone does nothing
            '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}
        };

        rst   = 1'b1;
        start = 1'b0;
        en    = 1'b0;
        up_dn = 1'b1;
`ifdef MOD_N_COUNTER_LOAD_EN
        load     = 1'b0;
        load_val = 3'd0;
`endif
        #2;
        @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i], 0, $sformatf("vec%0d", i));
        end

        // One-shot: up pass, DONE, restart downward, DONE again, reset from DONE
        apply('{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}, 1, "os_rst");
        apply('{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0}, 1, "os_start");
        apply('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0}, 1, "os_up1");
        apply('{1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0}, 1, "os_up2");
        apply('{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0}, 1, "os_up3");
        apply('{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1}, 1, "os_done");
        apply('{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1}, 1, "os_hold");
        apply('{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0}, 1, "os_restart");
        apply('{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0}, 1, "os_dn2");
        apply('{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0}, 1, "os_dn1");
        apply('{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0}, 1, "os_dn0");
        apply('{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1}, 1, "os_done2");
        apply('{1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}, 1, "os_rst_done");

`ifdef MOD_N_COUNTER_LOAD_EN
        // Load in RUN, out-of-range load ignored, load in IDLE keeps IDLE
        apply('{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}, 0, "ld_rst");
        apply('{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0}, 0, "ld_start");
        do_load(3'd2, 1'b1, 3'd2, 1'b1, "ld_run2");
        do_load(3'd5, 1'b1, 3'd3, 1'b1, "ld_bad5");
        apply('{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}, 0, "ld_rst2");
        do_load(3'd3, 1'b1, 3'd3, 1'b0, "ld_idle3");
        apply('{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0}, 0, "ld_idle_hold");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
